// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - opcode/funct constants, GPR indices and write-source enum for wb_regfile
package wb_regfile_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;

  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_GP   = 5'd28;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_LINK = 2'd2
  } wsrc_e;

endpackage

// File: rtl/wb_load_ext.sv
// rtl/wb_load_ext.sv - load data selection and extension; sub-word loads only with WB_SUBWORD_LOAD_EN
module wb_load_ext
  import wb_regfile_pkg::*;
(
  input  logic [31:0] dr_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [5:0]  op_i,
  output logic [31:0] data_o
);

`ifdef WB_SUBWORD_LOAD_EN
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_s = dr_i[7:0];
      2'd1:    byte_s = dr_i[15:8];
      2'd2:    byte_s = dr_i[23:16];
      default: byte_s = dr_i[31:24];
    endcase
    half_s = addr_lo_i[1] ? dr_i[31:16] : dr_i[15:0];
  end

  always_comb begin
    case (op_i)
      OP_LB:   data_o = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  data_o = {24'd0, byte_s};
      OP_LH:   data_o = {{16{half_s[15]}}, half_s};
      OP_LHU:  data_o = {16'd0, half_s};
      default: data_o = dr_i;
    endcase
  end
`else
  logic unused_sel;
  assign unused_sel = ^{addr_lo_i, op_i};
  assign data_o     = dr_i;
`endif

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback-stage decode and 32x32 GPR file with write-through bypass
// Optional sub-word loads (lb/lbu/lh/lhu) enabled by WB_SUBWORD_LOAD_EN.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter logic [31:0] GP_INIT = 32'h0000_1800,
  parameter logic [31:0] SP_INIT = 32'h0000_2FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_W,
  input  logic [31:0] PC4_W,
  input  logic [31:0] AO_W,
  input  logic [31:0] DR_W,
  input  logic [4:0]  RA1,
  input  logic [4:0]  RA2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic        WE_W,
  output logic [4:0]  WA_W,
  output logic [31:0] WD_W,
  output logic [31:0] RETIRED
);

  logic [5:0]  op, funct;
  logic [4:0]  rt, rd;
  logic        we_raw;
  wsrc_e       wsrc;
  logic [31:0] load_data;
  logic [31:0] gpr_q [0:31];
  logic [31:0] retired_q, retired_d;
  logic        unused_ir;

  assign op        = IR_W[31:26];
  assign rt        = IR_W[20:16];
  assign rd        = IR_W[15:11];
  assign funct     = IR_W[5:0];
  assign unused_ir = ^{IR_W[25:21], IR_W[10:6]};

  always_comb begin
    we_raw = 1'b0;
    WA_W   = rd;
    wsrc   = SRC_ALU;
    case (op)
      OP_RTYPE: begin
        if (funct == FN_ADDU || funct == FN_SUBU) begin
          we_raw = 1'b1;
        end else if (funct == FN_JALR) begin
          we_raw = 1'b1;
          wsrc   = SRC_LINK;
        end
      end
      OP_ORI, OP_LUI: begin
        we_raw = 1'b1;
        WA_W   = rt;
      end
`ifdef WB_SUBWORD_LOAD_EN
      OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: begin
`else
      OP_LW: begin
`endif
        we_raw = 1'b1;
        WA_W   = rt;
        wsrc   = SRC_MEM;
      end
      OP_JAL: begin
        we_raw = 1'b1;
        WA_W   = REG_RA;
        wsrc   = SRC_LINK;
      end
      default: we_raw = 1'b0;
    endcase
  end

  // Writes aimed at $0 are squashed here so forwarding logic never sees them.
  assign WE_W = we_raw && (WA_W != REG_ZERO);

  wb_load_ext u_load_ext (
    .dr_i      (DR_W),
    .addr_lo_i (AO_W[1:0]),
    .op_i      (op),
    .data_o    (load_data)
  );

  always_comb begin
    case (wsrc)
      SRC_MEM:  WD_W = load_data;
      SRC_LINK: WD_W = PC4_W + 32'd4;
      default:  WD_W = AO_W;
    endcase
  end

  always_comb begin
    if (RA1 == REG_ZERO)                RD1 = 32'd0;
    else if (WE_W && RA1 == WA_W)       RD1 = WD_W;
    else                                RD1 = gpr_q[RA1];
    if (RA2 == REG_ZERO)                RD2 = 32'd0;
    else if (WE_W && RA2 == WA_W)       RD2 = WD_W;
    else                                RD2 = gpr_q[RA2];
  end

  assign retired_d = (IR_W != 32'd0) ? retired_q + 32'd1 : retired_q;
  assign RETIRED   = retired_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      gpr_q         <= '{default: 32'd0};
      gpr_q[REG_GP] <= GP_INIT;
      gpr_q[REG_SP] <= SP_INIT;
      retired_q     <= 32'd0;
    end else begin
      if (WE_W) gpr_q[WA_W] <= WD_W;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard-based self-checking bench for wb_regfile
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR_W, PC4_W, AO_W, DR_W;
  logic [4:0]  RA1, RA2;
  logic [31:0] RD1, RD2, WD_W, RETIRED;
  logic        WE_W;
  logic [4:0]  WA_W;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk     (clk),
    .reset   (reset),
    .IR_W    (IR_W),
    .PC4_W   (PC4_W),
    .AO_W    (AO_W),
    .DR_W    (DR_W),
    .RA1     (RA1),
    .RA2     (RA2),
    .RD1     (RD1),
    .RD2     (RD2),
    .WE_W    (WE_W),
    .WA_W    (WA_W),
    .WD_W    (WD_W),
    .RETIRED (RETIRED)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t    sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_ret = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", obs, ~obs);
    end else begin
      it = sb_q.pop_front();
      check_eq(it.tag, obs, it.exp);
    end
  endtask

  task automatic drive(input logic [31:0] ir, input logic [31:0] pc4, input logic [31:0] ao,
                       input logic [31:0] dr, input logic [4:0] a1, input logic [4:0] a2);
    IR_W = ir; PC4_W = pc4; AO_W = ao; DR_W = dr; RA1 = a1; RA2 = a2;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset)                exp_ret = 32'd0;
    else if (IR_W != 32'd0)    exp_ret = exp_ret + 32'd1;
    @(negedge clk);
  endtask

  // push order must match pop order below
  task automatic expect_wb(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    sb_push({tag, "_we"}, {31'd0, we});
    if (we) begin
      sb_push({tag, "_wa"}, {27'd0, wa});
      sb_push({tag, "_wd"}, wd);
    end
  endtask

  task automatic observe_wb(input logic we);
    #1;
    sb_pop({31'd0, WE_W});
    if (we) begin
      sb_pop({27'd0, WA_W});
      sb_pop(WD_W);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    tick();
    reset = 1'b1;

    // reset state
    drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd28, 5'd29);
    sb_push("rst_gp", 32'h0000_1800);
    sb_push("rst_sp", 32'h0000_2FFC);
    sb_push("rst_ret", 32'd0);
    #1; sb_pop(RD1); sb_pop(RD2); sb_pop(RETIRED);
    RA1 = 5'd5;
    sb_push("rst_r5", 32'd0);
    #1; sb_pop(RD1);

    // ori $8 with same-cycle bypass
    drive(32'h3408_0000, 32'h0, 32'h0000_1234, 32'h0, 5'd8, 5'd0);
    expect_wb("ori", 1'b1, 5'd8, 32'h0000_1234);
    sb_push("ori_byp", 32'h0000_1234);
    observe_wb(1'b1); sb_pop(RD1);
    tick();
    drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd0);
    sb_push("ori_held", 32'h0000_1234);
    sb_push("ret_1", 32'd1);
    #1; sb_pop(RD1); sb_pop(RETIRED);

    // sub-word loads
    drive(32'h8009_0000, 32'h0, 32'h0000_1003, 32'h80AA_BBCC, 5'd0, 5'd0);
`ifdef WB_SUBWORD_LOAD_EN
    expect_wb("lb", 1'b1, 5'd9, 32'hFFFF_FF80); observe_wb(1'b1);
`else
    expect_wb("lb", 1'b0, 5'd0, 32'h0);         observe_wb(1'b0);
`endif
    tick();
    drive(32'h9009_0000, 32'h0, 32'h0000_1003, 32'h80AA_BBCC, 5'd0, 5'd0);
`ifdef WB_SUBWORD_LOAD_EN
    expect_wb("lbu", 1'b1, 5'd9, 32'h0000_0080); observe_wb(1'b1);
`else
    expect_wb("lbu", 1'b0, 5'd0, 32'h0);         observe_wb(1'b0);
`endif
    tick();
    drive(32'h8409_0000, 32'h0, 32'h0000_1002, 32'h80AA_BBCC, 5'd0, 5'd0);
`ifdef WB_SUBWORD_LOAD_EN
    expect_wb("lh", 1'b1, 5'd9, 32'hFFFF_80AA); observe_wb(1'b1);
`else
    expect_wb("lh", 1'b0, 5'd0, 32'h0);         observe_wb(1'b0);
`endif
    tick();

    // lw ignores address low bits
    drive(32'h8C0A_0000, 32'h0, 32'h0000_1001, 32'h1234_5678, 5'd0, 5'd0);
    expect_wb("lw", 1'b1, 5'd10, 32'h1234_5678); observe_wb(1'b1);
    tick();

    // jal then read $31 next cycle
    drive(32'h0C00_0100, 32'h0000_3004, 32'h0, 32'h0, 5'd0, 5'd0);
    expect_wb("jal", 1'b1, 5'd31, 32'h0000_3008); observe_wb(1'b1);
    tick();
    drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd10, 5'd31);
    sb_push("jal_ra", 32'h0000_3008);
    sb_push("lw_r10", 32'h1234_5678);
    #1; sb_pop(RD2); sb_pop(RD1);

    // non-writing encodings
    drive(32'h0000_0021, 32'h0, 32'h0000_DEAD, 32'h0, 5'd0, 5'd0);
    expect_wb("addu0", 1'b0, 5'd0, 32'h0);
    sb_push("addu0_rd", 32'd0);
    observe_wb(1'b0); sb_pop(RD1);
    tick();
    drive(32'hAC08_0000, 32'h0, 32'h0000_0040, 32'h0, 5'd0, 5'd0);
    expect_wb("sw", 1'b0, 5'd0, 32'h0); observe_wb(1'b0);
    tick();
    drive(32'h1000_0004, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    expect_wb("beq", 1'b0, 5'd0, 32'h0); observe_wb(1'b0);
    tick();
    drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    sb_push("ret_count", exp_ret);
    #1; sb_pop(RETIRED);

    // dual-port bypass of same index, jalr wrap, lui
    drive(32'h0000_6023, 32'h0, 32'h0000_CAFE, 32'h0, 5'd12, 5'd12);
    expect_wb("subu", 1'b1, 5'd12, 32'h0000_CAFE);
    sb_push("byp_p1", 32'h0000_CAFE);
    sb_push("byp_p2", 32'h0000_CAFE);
    observe_wb(1'b1); sb_pop(RD1); sb_pop(RD2);
    tick();
    drive(32'h0000_6809, 32'hFFFF_FFFC, 32'h0, 32'h0, 5'd12, 5'd13);
    expect_wb("jalr", 1'b1, 5'd13, 32'h0000_0000);
    sb_push("subu_r12", 32'h0000_CAFE);
    observe_wb(1'b1); sb_pop(RD1);
    tick();
    drive(32'h3C0E_0000, 32'h0, 32'hABCD_0000, 32'h0, 5'd14, 5'd13);
    expect_wb("lui", 1'b1, 5'd14, 32'hABCD_0000);
    sb_push("jalr_r13", 32'h0);
    observe_wb(1'b1); sb_pop(RD2);
    tick();

    // RETIRED wrap via preset counter
    drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd14, 5'd0);
    force dut.retired_q = 32'hFFFF_FFFF;
    tick();
    release dut.retired_q;
    exp_ret = 32'hFFFF_FFFF;
    drive(32'h1000_0004, 32'h0, 32'h0, 32'h0, 5'd14, 5'd0);
    tick();
    drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd14, 5'd0);
    sb_push("ret_wrap", exp_ret);
    sb_push("lui_r14", 32'hABCD_0000);
    #1; sb_pop(RETIRED); sb_pop(RD1);

    // reset while a write to $29 is pending
    reset = 1'b0;
    drive(32'h341D_0000, 32'h0, 32'h0000_5555, 32'h0, 5'd29, 5'd8);
    expect_wb("rst_wr", 1'b1, 5'd29, 32'h0000_5555);
    sb_push("rst_byp", 32'h0000_5555);
    observe_wb(1'b1); sb_pop(RD1);
    tick();
    reset = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd29, 5'd8);
    sb_push("rst_sp2", 32'h0000_2FFC);
    sb_push("rst_r8", 32'd0);
    sb_push("rst_ret2", exp_ret);
    #1; sb_pop(RD1); sb_pop(RD2); sb_pop(RETIRED);

    check_eq("sb_leftover", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
